// File: rtl/sys_feeder.sv
// -----------------------------------------------------------------------------
// sys_feeder
//
// Feeds a ROW x COL systolic array. A job begins with a one-cycle start that
// latches num_vec. The feeder then:
//   1. takes exactly ROW weight vectors. Each one is registered onto the north
//      edge with a one-cycle weight_en. The first vector accepted ends up in
//      the bottom row.
//   2. takes num_vec activation vectors. Each one is skewed onto the west edge,
//      with lane i delayed by i+1 cycles.
//   3. flushes for ROW cycles so the last vector leaves lane ROW-1, then
//      pulses done.
//
// Optional feature (macro SYS_FEEDER_STALL_CNT_EN):
//   adds stall_cnt, a saturating 32-bit count of STREAM cycles with no
//   activation offered.
//
// Parameters
//   IN_DATA_WIDTH  width of one weight/activation element
//   ROW            array rows = activation lanes
//   COL            array columns = weight lanes
//   NV_W           width of num_vec
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   start, num_vec           job request and vector count
//   busy, done               job in progress / one-cycle completion pulse
//   w_valid/w_ready/w_data   weight vector stream in
//   a_valid/a_ready/a_data   activation vector stream in
//   stall_cnt                (SYS_FEEDER_STALL_CNT_EN only) stall cycle count
//   weight_en, in_north      weight shift enable and data, array north edge
//   in_west, west_valid      skewed activations and lane valids, west edge
// -----------------------------------------------------------------------------
module sys_feeder #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int ROW           = 8,
    parameter int COL           = 8,
    parameter int NV_W          = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NV_W-1:0]              num_vec,
    output logic                         busy,
    output logic                         done,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [IN_DATA_WIDTH*COL-1:0] w_data,
    input  logic                         a_valid,
    output logic                         a_ready,
    input  logic [IN_DATA_WIDTH*ROW-1:0] a_data,
`ifdef SYS_FEEDER_STALL_CNT_EN
    output logic [31:0]                  stall_cnt,
`endif
    output logic                         weight_en,
    output logic [IN_DATA_WIDTH*COL-1:0] in_north,
    output logic [IN_DATA_WIDTH*ROW-1:0] in_west,
    output logic [ROW-1:0]               west_valid
);

    localparam int CNT_W = (ROW > 1) ? $clog2(ROW) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic [NV_W-1:0]                r_num_vec;
    logic [NV_W-1:0]                r_acnt;
    logic [CNT_W-1:0]               r_wcnt;
    logic [CNT_W-1:0]               r_fcnt;
    logic                           r_done;
    logic                           r_weight_en;
    logic [IN_DATA_WIDTH*COL-1:0]   r_in_north;

    logic                           w_busy;
    logic                           w_w_ready;
    logic                           w_a_ready;
    logic                           w_shift;
    logic                           w_done_set;
    logic                           w_w_hs;
    logic                           w_a_hs;
    logic                           w_start_acc;

    assign w_w_hs      = w_valid & w_w_ready;
    assign w_a_hs      = a_valid & w_a_ready;
    assign w_start_acc = start & (r_state == IDLE);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ---------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_busy     = 1'b1;
        w_w_ready  = 1'b0;
        w_a_ready  = 1'b0;
        w_shift    = 1'b0;
        w_done_set = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_next = LOAD_W;
                end
            end
            LOAD_W: begin
                w_w_ready = 1'b1;
                if (w_valid && (r_wcnt == CNT_W'(ROW - 1))) begin
                    if (r_num_vec != '0) begin
                        w_next = STREAM;
                    end else begin
                        w_next     = IDLE;
                        w_done_set = 1'b1;
                    end
                end
            end
            STREAM: begin
                w_a_ready = 1'b1;
                w_shift   = 1'b1;
                if (a_valid && (r_acnt == (r_num_vec - NV_W'(1)))) begin
                    w_next = FLUSH;
                end
            end
            FLUSH: begin
                w_shift = 1'b1;
                // Last vector is on lane ROW-1 during the final FLUSH cycle.
                if (r_fcnt == CNT_W'(ROW - 1)) begin
                    w_next     = IDLE;
                    w_done_set = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Job counters, done pulse, north-edge weight register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_vec   <= '0;
            r_acnt      <= '0;
            r_wcnt      <= '0;
            r_fcnt      <= '0;
            r_done      <= 1'b0;
            r_weight_en <= 1'b0;
            r_in_north  <= '0;
        end else begin
            r_done      <= w_done_set;
            r_weight_en <= w_w_hs;
            if (w_w_hs) begin
                r_in_north <= w_data;
                r_wcnt     <= r_wcnt + CNT_W'(1);
            end
            if (w_a_hs) begin
                r_acnt <= r_acnt + NV_W'(1);
            end
            if (r_state == FLUSH) begin
                r_fcnt <= r_fcnt + CNT_W'(1);
            end
            // start is only accepted in IDLE, so this never collides with
            // the handshake or flush updates above.
            if (w_start_acc) begin
                r_num_vec <= num_vec;
                r_acnt    <= '0;
                r_wcnt    <= '0;
                r_fcnt    <= '0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // West-edge skew lines: lane i is a shift register of depth i+1.
    // A cycle without an activation handshake enters as a zero bubble.
    // Outside STREAM/FLUSH the lines are held at zero.
    // ---------------------------------------------------------------------
    for (genvar gi = 0; gi < ROW; gi++) begin : g_lane
        logic [IN_DATA_WIDTH-1:0] r_dat [0:gi];
        logic [gi:0]              r_vld;

        always_ff @(posedge clk) begin
            if (rst || !w_shift) begin
                for (int d = 0; d <= gi; d++) begin
                    r_dat[d] <= '0;
                end
                r_vld <= '0;
            end else begin
                r_dat[0] <= w_a_hs ? a_data[gi*IN_DATA_WIDTH +: IN_DATA_WIDTH] : '0;
                r_vld[0] <= w_a_hs;
                for (int d = 1; d <= gi; d++) begin
                    r_dat[d] <= r_dat[d-1];
                    r_vld[d] <= r_vld[d-1];
                end
            end
        end

        assign in_west[gi*IN_DATA_WIDTH +: IN_DATA_WIDTH] = r_dat[gi];
        assign west_valid[gi]                             = r_vld[gi];
    end

`ifdef SYS_FEEDER_STALL_CNT_EN
    // ---------------------------------------------------------------------
    // Stall counter: counts STREAM cycles with nothing offered, saturating
    // ---------------------------------------------------------------------
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_stall_cnt <= '0;
        end else if ((r_state == STREAM) && !a_valid && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign busy      = w_busy;
    assign done      = r_done;
    assign w_ready   = w_w_ready;
    assign a_ready   = w_a_ready;
    assign weight_en = r_weight_en;
    assign in_north  = r_in_north;

endmodule

// File: tb/tb_sys_feeder.sv
// -----------------------------------------------------------------------------
// tb_sys_feeder
//
// Self-checking bench for sys_feeder with ROW = COL = 8 and 8-bit elements.
// Expected outputs are queued as stimulus is applied:
//   - north weights
//   - activation vectors, checked on every west lane at its skewed cycle
//   - done pulses
// Each queue is consumed when the DUT is due to produce the output.
// -----------------------------------------------------------------------------
module tb_sys_feeder;

    localparam int W   = 8;
    localparam int R   = 8;
    localparam int C   = 8;
    localparam int NVW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [NVW-1:0]   num_vec;
    logic             busy;
    logic             done;
    logic             w_valid;
    logic             w_ready;
    logic [W*C-1:0]   w_data;
    logic             a_valid;
    logic             a_ready;
    logic [W*R-1:0]   a_data;
    logic             weight_en;
    logic [W*C-1:0]   in_north;
    logic [W*R-1:0]   in_west;
    logic [R-1:0]     west_valid;
`ifdef SYS_FEEDER_STALL_CNT_EN
    logic [31:0]      stall_cnt;
`endif

    sys_feeder #(
        .IN_DATA_WIDTH (W),
        .ROW           (R),
        .COL           (C),
        .NV_W          (NVW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_vec    (num_vec),
        .busy       (busy),
        .done       (done),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_data     (a_data),
`ifdef SYS_FEEDER_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .weight_en  (weight_en),
        .in_north   (in_north),
        .in_west    (in_west),
        .west_valid (west_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W*R-1:0] vec;
        int             hs;
    } act_t;

    typedef struct {
        logic [W*C-1:0] data;
        int             due;
    } nrt_t;

    act_t           act_q[$];
    nrt_t           north_q[$];
    int             done_q[$];
    logic [W*C-1:0] last_north;
    int             cyc;
    int             n_cmp;
    int             n_err;

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic logic [W*R-1:0] mk_vec(input int base);
        logic [W*R-1:0] v;
        for (int i = 0; i < R; i++) begin
            v[i*W +: W] = W'(base + i + 1);
        end
        return v;
    endfunction

    function automatic logic [W*C-1:0] mk_w(input int k);
        logic [W*C-1:0] v;
        for (int j = 0; j < C; j++) begin
            v[j*W +: W] = W'(8'h80 + k*16 + j);
        end
        return v;
    endfunction

    task automatic check_cycle();
        logic           exp_v;
        logic [W-1:0]   exp_d;
        logic           exp_en;
        logic           exp_done;
        for (int i = 0; i < R; i++) begin
            exp_v = 1'b0;
            exp_d = '0;
            foreach (act_q[k]) begin
                if (act_q[k].hs + 1 + i == cyc) begin
                    exp_v = 1'b1;
                    exp_d = act_q[k].vec[i*W +: W];
                end
            end
            cmp($sformatf("west_valid[%0d]", i), 64'(west_valid[i]), 64'(exp_v));
            cmp($sformatf("in_west[%0d]", i), 64'(in_west[i*W +: W]), 64'(exp_d));
        end
        while (act_q.size() > 0 && act_q[0].hs + R <= cyc) begin
            void'(act_q.pop_front());
        end

        exp_en = (north_q.size() > 0) && (north_q[0].due == cyc);
        if (exp_en) begin
            last_north = north_q[0].data;
            void'(north_q.pop_front());
        end
        cmp("weight_en", 64'(weight_en), 64'(exp_en));
        cmp("in_north", 64'(in_north), 64'(last_north));

        exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
        if (exp_done) begin
            void'(done_q.pop_front());
        end
        cmp("done", 64'(done), 64'(exp_done));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic do_start(input int nv, input logic hold);
        start   = 1'b1;
        num_vec = NVW'(nv);
        tick();
        start   = hold;
        cmp("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic load_weights(input int nv);
        for (int k = 0; k < R; k++) begin
            w_valid = 1'b1;
            w_data  = mk_w(k + nv * 3);
            cmp("w_ready_load", 64'(w_ready), 64'd1);
            cmp("a_ready_load", 64'(a_ready), 64'd0);
            north_q.push_back('{w_data, cyc + 1});
            if (k == R - 1 && nv == 0) begin
                done_q.push_back(cyc + 1);
            end
            tick();
        end
        w_valid = 1'b0;
        w_data  = '0;
        start   = 1'b0;
    endtask

    task automatic send_vec(input logic [W*R-1:0] v, input logic last);
        a_valid = 1'b1;
        a_data  = v;
        cmp("a_ready_stream", 64'(a_ready), 64'd1);
        act_q.push_back('{v, cyc});
        if (last) begin
            done_q.push_back(cyc + R + 1);
        end
        tick();
        a_valid = 1'b0;
        a_data  = '0;
    endtask

    task automatic gap(input int n);
        for (int g = 0; g < n; g++) begin
            a_valid = 1'b0;
            a_data  = {(W*R){1'b1}};
            cmp("a_ready_gap", 64'(a_ready), 64'd1);
            tick();
        end
        a_data = '0;
    endtask

    task automatic drain(input int n);
        for (int d = 0; d < n; d++) begin
            tick();
        end
    endtask

    initial begin
        cyc        = 0;
        n_cmp      = 0;
        n_err      = 0;
        last_north = '0;
        rst        = 1'b1;
        start      = 1'b0;
        num_vec    = '0;
        w_valid    = 1'b0;
        w_data     = '0;
        a_valid    = 1'b0;
        a_data     = '0;

        // Reset state
        tick();
        tick();
        cmp("rst_busy", 64'(busy), 64'd0);
        cmp("rst_w_ready", 64'(w_ready), 64'd0);
        cmp("rst_a_ready", 64'(a_ready), 64'd0);
`ifdef SYS_FEEDER_STALL_CNT_EN
        cmp("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        rst = 1'b0;
        tick();

        // Job A: num_vec=3, back-to-back weights, gapless activations
        do_start(3, 1'b0);
        load_weights(3);
        send_vec(mk_vec(0), 1'b0);
        send_vec(mk_vec(16), 1'b0);
        send_vec(mk_vec(32), 1'b1);
        drain(R + 3);
        cmp("jobA_idle_busy", 64'(busy), 64'd0);

        // Job B: 2-cycle gap between vectors 1 and 2, start held during load
        do_start(3, 1'b1);
        load_weights(3);
        send_vec(mk_vec(48), 1'b0);
        send_vec(mk_vec(64), 1'b0);
        gap(2);
        send_vec(mk_vec(96), 1'b1);
        drain(R + 3);
        cmp("jobB_idle_busy", 64'(busy), 64'd0);
`ifdef SYS_FEEDER_STALL_CNT_EN
        cmp("jobB_stall_cnt", 64'(stall_cnt), 64'd2);
`endif

        // Job C: num_vec=0, done right after the last weight
        do_start(0, 1'b0);
        load_weights(0);
        cmp("jobC_busy", 64'(busy), 64'd0);
        drain(3);

        // Job D: abort mid-STREAM with start and a handshake in the same cycle
        do_start(3, 1'b0);
        load_weights(3);
        send_vec(mk_vec(112), 1'b0);
        gap(1);
        rst     = 1'b1;
        start   = 1'b1;
        a_valid = 1'b1;
        a_data  = mk_vec(128);
        act_q.delete();
        north_q.delete();
        done_q.delete();
        last_north = '0;
        tick();
        cmp("abort_busy", 64'(busy), 64'd0);
        cmp("abort_w_ready", 64'(w_ready), 64'd0);
        cmp("abort_a_ready", 64'(a_ready), 64'd0);
        cmp("abort_west_valid", 64'(west_valid), 64'd0);
`ifdef SYS_FEEDER_STALL_CNT_EN
        cmp("abort_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        rst     = 1'b0;
        start   = 1'b0;
        a_valid = 1'b0;
        a_data  = '0;
        tick();
        cmp("post_abort_busy", 64'(busy), 64'd0);
        drain(2);

        // Job E: normal job after the abort
        do_start(3, 1'b0);
        load_weights(3);
        send_vec(mk_vec(144), 1'b0);
        send_vec(mk_vec(160), 1'b0);
        gap(2);
        send_vec(mk_vec(192), 1'b1);
        drain(R + 3);
        cmp("jobE_idle_busy", 64'(busy), 64'd0);
`ifdef SYS_FEEDER_STALL_CNT_EN
        cmp("jobE_stall_cnt", 64'(stall_cnt), 64'd2);
`endif

        cmp("act_q_left", 64'(act_q.size()), 64'd0);
        cmp("north_q_left", 64'(north_q.size()), 64'd0);
        cmp("done_q_left", 64'(done_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
